// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// State enum, access-size codes, AXI response codes.
package ysyx_25010008_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_e;

  localparam logic [1:0] SIZE_B    = 2'd0;
  localparam logic [1:0] SIZE_H    = 2'd1;
  localparam logic [1:0] SIZE_W    = 2'd2;
  localparam logic [1:0] SIZE_W3   = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // code 3 aliases word, so size[1] marks any word access
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SIZE_H) && off[0]) ||
           (size[1] && (off != 2'd0));
  endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_align.sv
// Byte-lane steering: store strobes/data and load
// shift plus zero/sign extension.
module ysyx_25010008_lsu_align
  import ysyx_25010008_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [3:0]  base;
  logic [31:0] shifted;

  assign shamt   = {offset, 3'b000};
  assign wstrb   = base << offset;
  assign wdata   = store_data << shamt;
  assign shifted = load_raw >> shamt;

  always_comb begin
    base = 4'b1111;
    unique case (1'b1)
      size == SIZE_B: base = 4'b0001;
      size == SIZE_H: base = 4'b0011;
      default:        base = 4'b1111;
    endcase
  end

  always_comb begin
    load_data = shifted;
    unique case (1'b1)
      size == SIZE_B:
        load_data = {{24{sign_ext & shifted[7]}},
                     shifted[7:0]};
      size == SIZE_H:
        load_data = {{16{sign_ext & shifted[15]}},
                     shifted[15:0]};
      default:
        load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: request handshake to AXI-lite master.
// YSYX_25010008_LSU_MISALIGN_TRAP_EN: trap misaligned h/w.
module ysyx_25010008_lsu
  import ysyx_25010008_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  state_e      state, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        signed_q, wen_q, err_q;
  logic        aw_done, w_done;
  logic        aw_ok, w_ok, trap;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

`ifdef YSYX_25010008_LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  ysyx_25010008_lsu_align u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .sign_ext   (signed_q),
    .store_data (wdata_q),
    .load_raw   (rdata_q),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !wen_q) ? al_load
                                             : 32'd0;

  assign arvalid = (state == S_AR);
  assign rready  = (state == S_AR) || (state == S_R);
  assign araddr  = arvalid ? addr_q : 32'd0;

  assign awvalid = (state == S_AW_W) && !aw_done;
  assign wvalid  = (state == S_AW_W) && !w_done;
  assign bready  = (state == S_AW_W) || (state == S_B);
  assign awaddr  = awvalid ? addr_q : 32'd0;
  assign wdata   = wvalid ? al_wdata : 32'd0;
  assign wstrb   = wvalid ? al_wstrb : 4'd0;

  assign aw_ok = aw_done | (awvalid & awready);
  assign w_ok  = w_done | (wvalid & wready);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (req_valid)
          state_n = trap    ? S_RESP :
                    req_wen ? S_AW_W : S_AR;
      S_AR:
        if (arready) state_n = rvalid ? S_RESP : S_R;
      S_R:
        if (rvalid) state_n = S_RESP;
      S_AW_W:
        if (aw_ok && w_ok)
          state_n = bvalid ? S_RESP : S_B;
      S_B:
        if (bvalid) state_n = S_RESP;
      S_RESP:
        if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      size_q   <= SIZE_B;
      signed_q <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE:
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            signed_q <= req_signed;
            wen_q    <= req_wen;
            rdata_q  <= 32'd0;
            err_q    <= trap;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        S_AR:
          if (arready && rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != RESP_OKAY);
          end
        S_R:
          if (rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != RESP_OKAY);
          end
        S_AW_W: begin
          aw_done <= aw_ok;
          w_done  <= w_ok;
          if (aw_ok && w_ok && bvalid)
            err_q <= (bresp != RESP_OKAY);
        end
        S_B:
          if (bvalid) err_q <= (bresp != RESP_OKAY);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Directed plus randomized bench for the LSU with an
// arithmetic byte-lane reference model.
module tb_ysyx_25010008_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 0, req_ready, req_wen = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        req_signed = 0;
  logic        resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, arready = 0, rready;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0, bresp = 0;
  logic        rvalid = 0, awvalid, awready = 0;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 0, bready, bvalid = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ysyx_25010008_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_strb(
    input logic [1:0] s, input int off);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(s)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(
    input logic [31:0] d, input int off);
    logic [63:0] t;
    t = {32'd0, d} * (64'd1 << (8 * off));
    return t[31:0];
  endfunction

  function automatic logic [31:0] m_load(
    input logic [31:0] d, input int off,
    input logic [1:0] s, input logic sgn);
    longint v, span;
    logic [63:0] t;
    v = longint'({32'd0, d}) / (longint'(1) << (8 * off));
    span = longint'(1) << (8 * nbytes(s));
    v = v % span;
    if (sgn && v >= span / 2) v = v - span;
    t = v;
    return t[31:0];
  endfunction

  task automatic check_resp(input logic [31:0] exp_d,
                            input logic exp_e,
                            input int hold);
    for (int c = 0; c <= hold; c++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_rdata", resp_rdata, exp_d);
      check("resp_err", resp_err, exp_e);
      check("resp_req_ready", req_ready, 0);
      check("resp_bus_idle",
            {arvalid, rready, awvalid, wvalid, bready}, 0);
      resp_ready = (c == hold);
      @(negedge clock);
    end
    resp_ready = 0;
    check("after_resp_valid", resp_valid, 0);
    check("after_req_ready", req_ready, 1);
  endtask

  task automatic do_load(input logic [31:0] a,
                         input logic [1:0] s,
                         input logic sgn,
                         input logic [31:0] rd,
                         input logic [1:0] rr,
                         input int ard, input int rdl,
                         input logic co, input int hold);
    int off = int'(a[1:0]);
    req_valid = 1; req_wen = 0; req_addr = a;
    req_size = s; req_signed = sgn;
    req_wdata = $urandom;
    check("ld_req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 0; req_addr = $urandom;
    for (int c = 0; c <= ard; c++) begin
      check("ld_arvalid", arvalid, 1);
      check("ld_araddr", araddr, a);
      check("ld_rready", rready, 1);
      check("ld_awvalid", awvalid, 0);
      arready = (c == ard);
      if (c == ard && co) begin
        rvalid = 1; rdata = rd; rresp = rr;
      end
      @(negedge clock);
    end
    arready = 0; rvalid = 0;
    if (!co) begin
      for (int c = 0; c <= rdl; c++) begin
        check("r_arvalid", arvalid, 0);
        check("r_araddr", araddr, 0);
        check("r_rready", rready, 1);
        rvalid = (c == rdl);
        rdata = (c == rdl) ? rd : $urandom;
        rresp = rr;
        @(negedge clock);
      end
      rvalid = 0;
    end
    rdata = $urandom; rresp = 0;
    check_resp(m_load(rd, off, s, sgn), rr != 2'b00, hold);
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [1:0] s,
                          input logic [31:0] wd,
                          input logic [1:0] br,
                          input int awd, input int wdl,
                          input logic bsame, input int bd,
                          input int hold);
    int off = int'(a[1:0]);
    int mx = (awd > wdl) ? awd : wdl;
    req_valid = 1; req_wen = 1; req_addr = a;
    req_size = s; req_wdata = wd; req_signed = $urandom;
    check("st_req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 0; req_wdata = $urandom;
    for (int c = 0; c <= mx; c++) begin
      check("st_awvalid", awvalid, c <= awd);
      check("st_awaddr", awaddr, (c <= awd) ? a : 0);
      check("st_wvalid", wvalid, c <= wdl);
      check("st_wstrb", wstrb,
            (c <= wdl) ? m_strb(s, off) : 4'd0);
      check("st_wdata", wdata,
            (c <= wdl) ? m_wdata(wd, off) : 0);
      check("st_bready", bready, 1);
      check("st_arvalid", arvalid, 0);
      awready = (c == awd);
      wready  = (c == wdl);
      bvalid  = bsame && (c == mx);
      bresp   = br;
      @(negedge clock);
    end
    awready = 0; wready = 0; bvalid = 0;
    if (!bsame) begin
      for (int c = 0; c <= bd; c++) begin
        check("b_valids", {awvalid, wvalid}, 0);
        check("b_wstrb", wstrb, 0);
        check("b_bready", bready, 1);
        bvalid = (c == bd); bresp = br;
        @(negedge clock);
      end
      bvalid = 0;
    end
    bresp = 0;
    check_resp(32'd0, br != 2'b00, hold);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_outs",
          {resp_valid, resp_err, arvalid, rready,
           awvalid, wvalid, bready}, 0);
    check("rst_data", resp_rdata | araddr | awaddr | wdata,
          0);
    reset = 0;
    @(negedge clock);

    do_load(32'h8000_0003, 2'd0, 1, 32'h80FF_FFFF, 2'b00,
            3, 0, 0, 0);
    check("lb_value", m_load(32'h80FF_FFFF, 3, 0, 1),
          32'hFFFF_FF80);
    do_store(32'h8000_0002, 2'd1, 32'h0000_1234, 2'b00,
             0, 2, 0, 1, 0);
    do_load(32'h8000_0000, 2'd2, 0, 32'hDEAD_BEEF, 2'b10,
            0, 1, 0, 4);
    do_store(32'h8000_0004, 2'd2, 32'hCAFE_F00D, 2'b00,
             1, 1, 1, 0, 0);
    do_load(32'h8000_0001, 2'd0, 0, 32'h1234_8A56, 2'b00,
            1, 0, 1, 1);
    do_store(32'h0000_0010, 2'd3, 32'h0BAD_F00D, 2'b11,
             2, 0, 0, 0, 1);

    // reset while the read channel is pending
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0008;
    req_size = 2'd2;
    @(negedge clock);
    req_valid = 0; arready = 1;
    @(negedge clock);
    arready = 0;
    check("mid_r_rready", rready, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_idle", {arvalid, resp_valid}, 0);

`ifdef YSYX_25010008_LSU_MISALIGN_TRAP_EN
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0002;
    req_size = 2'd2;
    @(negedge clock);
    req_valid = 0;
    check("trap_arvalid", arvalid, 0);
    check("trap_resp", {resp_valid, resp_err}, 2'b11);
    check("trap_rdata", resp_rdata, 0);
    resp_ready = 1;
    @(negedge clock);
    resp_ready = 0;
    check("trap_idle", req_ready, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 3));
`ifdef YSYX_25010008_LSU_MISALIGN_TRAP_EN
      a[1:0] = 2'd0;
`endif
      if ($urandom_range(0, 1) == 1)
        do_store(a, s, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_load(a, s, 1'($urandom_range(0, 1)), $urandom,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
